// File: rtl/alu_dispatch_unit.sv
// ALU dispatch unit: accepts a function code, pulses the matching execution unit,
// waits for its done strobe (or a timeout) and returns a registered completion record.
module alu_dispatch_unit #(
  parameter int FUN_WIDTH = 2,
  parameter int NUM_UNITS = 4,
  parameter int TIMEOUT   = 16,
  parameter int TO_WIDTH  = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 in_valid,
  input  logic [FUN_WIDTH-1:0] in_fun,
  output logic                 in_ready,
  output logic [NUM_UNITS-1:0] unit_enable,
  input  logic [NUM_UNITS-1:0] unit_done,
  output logic                 out_valid,
  output logic [FUN_WIDTH-1:0] out_fun,
  output logic                 out_err,
  output logic                 out_timeout,
  input  logic                 out_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // One extra bit so NUM_UNITS == 2**FUN_WIDTH is representable.
  localparam logic [FUN_WIDTH:0]  NUM_UNITS_C = (FUN_WIDTH + 1)'(NUM_UNITS);
  localparam logic [TO_WIDTH-1:0] TIMEOUT_C   = TO_WIDTH'(TIMEOUT);
  localparam logic [TO_WIDTH-1:0] CNT_ONE_C   = TO_WIDTH'(1'b1);
  localparam logic [TO_WIDTH-1:0] CNT_ZERO_C  = TO_WIDTH'(1'b0);

  function automatic logic [NUM_UNITS-1:0] onehot_f(input logic [FUN_WIDTH-1:0] fun);
    logic [NUM_UNITS-1:0] vec;
    vec = {NUM_UNITS{1'b0}};
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (fun == FUN_WIDTH'(i)) begin
        vec[i] = 1'b1;
      end else begin
        vec[i] = 1'b0;
      end
    end
    return vec;
  endfunction

  state_e               state_q, state_d;
  logic [FUN_WIDTH-1:0] fun_q, fun_d;
  logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
  logic                 in_ready_q, in_ready_d;
  logic [NUM_UNITS-1:0] unit_enable_q, unit_enable_d;
  logic                 out_valid_q, out_valid_d;
  logic [FUN_WIDTH-1:0] out_fun_q, out_fun_d;
  logic                 out_err_q, out_err_d;
  logic                 out_timeout_q, out_timeout_d;
  logic                 busy_q, busy_d;

  logic                 in_legal_s;
  logic                 done_sel_s;
  logic [TO_WIDTH-1:0]  cnt_inc_s;

  // Request legality, own-unit done selection and counter increment.
  always_comb begin
    in_legal_s = ({1'b0, in_fun} < NUM_UNITS_C);
    done_sel_s = |(unit_done & onehot_f(fun_q));
    cnt_inc_s  = cnt_q + CNT_ONE_C;
  end

  // Next-state and next-output logic for the dispatch FSM.
  always_comb begin
    state_d       = state_q;
    fun_d         = fun_q;
    cnt_d         = cnt_q;
    in_ready_d    = in_ready_q;
    unit_enable_d = {NUM_UNITS{1'b0}};
    out_valid_d   = out_valid_q;
    out_fun_d     = out_fun_q;
    out_err_d     = out_err_q;
    out_timeout_d = out_timeout_q;
    busy_d        = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          fun_d      = in_fun;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          if (in_legal_s) begin
            state_d       = ST_ISSUE;
            unit_enable_d = onehot_f(in_fun);
          end else begin
            // Illegal code skips the unit bank entirely.
            state_d       = ST_RESP;
            out_valid_d   = 1'b1;
            out_fun_d     = in_fun;
            out_err_d     = 1'b1;
            out_timeout_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        cnt_d   = CNT_ZERO_C;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        // Done is checked first so it wins over a simultaneous timeout.
        if (done_sel_s) begin
          state_d       = ST_RESP;
          out_valid_d   = 1'b1;
          out_fun_d     = fun_q;
          out_err_d     = 1'b0;
          out_timeout_d = 1'b0;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          cnt_d         = cnt_inc_s;
          state_d       = ST_RESP;
          out_valid_d   = 1'b1;
          out_fun_d     = fun_q;
          out_err_d     = 1'b1;
          out_timeout_d = 1'b1;
        end else begin
          cnt_d   = cnt_inc_s;
          state_d = ST_WAIT;
        end
      end

      ST_RESP: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      fun_q         <= {FUN_WIDTH{1'b0}};
      cnt_q         <= CNT_ZERO_C;
      in_ready_q    <= 1'b1;
      unit_enable_q <= {NUM_UNITS{1'b0}};
      out_valid_q   <= 1'b0;
      out_fun_q     <= {FUN_WIDTH{1'b0}};
      out_err_q     <= 1'b0;
      out_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fun_q         <= fun_d;
      cnt_q         <= cnt_d;
      in_ready_q    <= in_ready_d;
      unit_enable_q <= unit_enable_d;
      out_valid_q   <= out_valid_d;
      out_fun_q     <= out_fun_d;
      out_err_q     <= out_err_d;
      out_timeout_q <= out_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign unit_enable = unit_enable_q;
  assign out_valid   = out_valid_q;
  assign out_fun     = out_fun_q;
  assign out_err     = out_err_q;
  assign out_timeout = out_timeout_q;
  assign busy        = busy_q;

  alu_dispatch_unit_chk #(
    .NUM_UNITS (NUM_UNITS)
  ) u_chk (
    .clk         (CLK),
    .rst         (RST),
    .in_ready    (in_ready_q),
    .busy        (busy_q),
    .out_valid   (out_valid_q),
    .unit_enable (unit_enable_q)
  );

endmodule

// Protocol invariants of the dispatch unit outputs.
module alu_dispatch_unit_chk #(
  parameter int NUM_UNITS = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 in_ready,
  input logic                 busy,
  input logic                 out_valid,
  input logic [NUM_UNITS-1:0] unit_enable
);

  a_enable_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(unit_enable));
  a_ready_not_busy: assert property (@(posedge clk) disable iff (rst) in_ready == !busy);
  a_valid_not_ready: assert property (@(posedge clk) disable iff (rst) out_valid |-> !in_ready);
  a_enable_busy: assert property (@(posedge clk) disable iff (rst) (|unit_enable) |-> busy);

endmodule
